// File: rtl/huff_prob_sorter.sv
// Stable descending sorter of (symbol, probability) pairs using an odd-even transposition
// network, one pass per cycle. Optional macro SORT_EARLY_EXIT_EN enables early termination.
module huff_prob_sorter #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned SYM_W  = 8,
    parameter int unsigned PROB_W = 8
) (
    input  logic                       clock,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DEPTH*SYM_W-1:0]     in_sym,
    input  logic [DEPTH*PROB_W-1:0]    in_prob,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DEPTH*SYM_W-1:0]     out_sym,
    output logic [DEPTH*PROB_W-1:0]    out_prob,
    output logic [$clog2(DEPTH+1)-1:0] out_nz
`ifdef SORT_EARLY_EXIT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] out_passes
`endif
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StSort, StDone} state_e;

    state_e                state_q, state_d;
    logic                  init_q;
    logic [CntW-1:0]       pass_q;
    logic [CntW-1:0]       nz_q;
    logic [SYM_W-1:0]      sym_q  [DEPTH];
    logic [PROB_W-1:0]     prob_q [DEPTH];
    logic [SYM_W-1:0]      sort_sym  [DEPTH];
    logic [PROB_W-1:0]     sort_prob [DEPTH];
    logic [CntW-1:0]       nz_cnt;
    logic                  accept;
    logic                  do_pass;
    logic                  early_stop;
`ifdef SORT_EARLY_EXIT_EN
    logic                  swapped;
    logic [1:0]            sw_q;
`endif

    // One transposition pass; pairs are disjoint so every compare reads the current registers.
    always_comb begin
        sort_sym  = sym_q;
        sort_prob = prob_q;
`ifdef SORT_EARLY_EXIT_EN
        swapped   = 1'b0;
`endif
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (((i % 2) == 1) == pass_q[0] && prob_q[i] < prob_q[i+1]) begin
                sort_sym[i]    = sym_q[i+1];
                sort_sym[i+1]  = sym_q[i];
                sort_prob[i]   = prob_q[i+1];
                sort_prob[i+1] = prob_q[i];
`ifdef SORT_EARLY_EXIT_EN
                swapped        = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        nz_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (in_prob[i*PROB_W +: PROB_W] != '0) begin
                nz_cnt = nz_cnt + CntW'(1);
            end
        end
    end

`ifdef SORT_EARLY_EXIT_EN
    // sw_q is preset on accept, so it only reads clear after two real no-swap passes.
    assign early_stop = (sw_q == 2'b00);
`else
    assign early_stop = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        do_pass   = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = init_q;
                if (in_valid && init_q) begin
                    accept  = 1'b1;
                    state_d = StSort;
                end
            end
            StSort: begin
                if (pass_q == CntW'(DEPTH) || early_stop) begin
                    state_d = StDone;
                end else begin
                    do_pass = 1'b1;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                // Consuming a result and accepting the next vector may share one edge.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept  = 1'b1;
                        state_d = StSort;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            init_q  <= 1'b0;
            pass_q  <= '0;
            nz_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sym_q[i]  <= '0;
                prob_q[i] <= '0;
            end
`ifdef SORT_EARLY_EXIT_EN
            sw_q    <= 2'b00;
`endif
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            if (accept) begin
                pass_q <= '0;
                nz_q   <= nz_cnt;
                for (int i = 0; i < DEPTH; i++) begin
                    sym_q[i]  <= in_sym[i*SYM_W +: SYM_W];
                    prob_q[i] <= in_prob[i*PROB_W +: PROB_W];
                end
`ifdef SORT_EARLY_EXIT_EN
                sw_q   <= 2'b11;
`endif
            end else if (do_pass) begin
                pass_q <= pass_q + CntW'(1);
                sym_q  <= sort_sym;
                prob_q <= sort_prob;
`ifdef SORT_EARLY_EXIT_EN
                sw_q   <= {sw_q[0], swapped};
`endif
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            out_sym[i*SYM_W +: SYM_W]    = sym_q[i];
            out_prob[i*PROB_W +: PROB_W] = prob_q[i];
        end
    end

    assign out_nz = nz_q;
`ifdef SORT_EARLY_EXIT_EN
    assign out_passes = pass_q;
`endif

endmodule
